psram_arbiter: RTL and testbench

PSRAM_ARBITER -- requirements
Module: psram_arbiter

---
 rtl/psram_arbiter.sv | 101 ++++++++++
 tb/tb_psram_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/psram_arbiter.sv
// psram_arbiter: three-port arbiter (port 0 priority with starvation guard, ports 1/2 round-robin) in front of a PSRAM controller
// ports: i_clk/i_rst clock and async active-high reset; i_req/i_we/i_addrN/i_dinN per-port requests;
//        o_ack/o_rdata completion and read data; o_ready init done; o_gnt current owner (3 = none);
//        o_mem_stb/o_mem_we/o_mem_addr/o_mem_din controller command; i_mem_busy/i_mem_done/i_mem_dout controller status
module psram_arbiter #(
  parameter int STARVE_LIMIT = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [2:0]  i_req,
  input  logic [2:0]  i_we,
  input  logic [23:0] i_addr0,
  input  logic [23:0] i_addr1,
  input  logic [23:0] i_addr2,
  input  logic [15:0] i_din0,
  input  logic [15:0] i_din1,
  input  logic [15:0] i_din2,
  output logic [2:0]  o_ack,
  output logic [15:0] o_rdata,
  output logic        o_ready,
  output logic [1:0]  o_gnt,
  output logic        o_mem_stb,
  output logic        o_mem_we,
  output logic [23:0] o_mem_addr,
  output logic [15:0] o_mem_din,
  input  logic        i_mem_busy,
  input  logic        i_mem_done,
  input  logic [15:0] i_mem_dout
);
  localparam logic [2:0] INIT  = 3'd0;
  localparam logic [2:0] IDLE  = 3'd1;
  localparam logic [2:0] ISSUE = 3'd2;
  localparam logic [2:0] WAIT  = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  logic [2:0]  state;
  logic        rr;
  logic [3:0]  starve;
  logic        gen;
  logic        skip0;
  logic [1:0]  win;
  logic [23:0] win_addr;
  logic [15:0] win_din;
  always_comb begin
    gen      = |i_req[2:1];
    skip0    = gen && starve == LIMIT;
    win      = i_req[0] && !skip0 ? 2'd0 : i_req[1] && (!i_req[2] || !rr) ? 2'd1 : 2'd2;
    win_addr = win == 2'd0 ? i_addr0 : win == 2'd1 ? i_addr1 : i_addr2;
    win_din  = win == 2'd0 ? i_din0 : win == 2'd1 ? i_din1 : i_din2;
  end
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      state      <= INIT;
      o_ack      <= '0;
      o_rdata    <= '0;
      o_ready    <= 1'b0;
      o_gnt      <= 2'd3;
      o_mem_stb  <= 1'b0;
      o_mem_we   <= 1'b0;
      o_mem_addr <= '0;
      o_mem_din  <= '0;
      rr         <= 1'b0;
      starve     <= '0;
    end else begin
      o_ack <= '0;
      case (state)
        INIT: if (!i_mem_busy && i_mem_done) begin
          o_ready <= 1'b1;
          state   <= IDLE;
        end
        IDLE: if (|i_req) begin
          o_mem_we   <= i_we[win];
          o_mem_addr <= win_addr;
          o_mem_din  <= win_din;
          o_mem_stb  <= 1'b1;
          o_gnt      <= win;
          state      <= ISSUE;
          if (win == 2'd0) begin
            if (gen && starve != LIMIT) starve <= starve + 4'd1;
          end else begin
            starve <= '0;
            rr     <= win == 2'd1;
          end
        end
        ISSUE: if (i_mem_busy) begin
          o_mem_stb <= 1'b0;
          state     <= WAIT;
        end
        WAIT: if (!i_mem_busy && i_mem_done) begin
          o_ack <= 3'b001 << o_gnt;
          if (!o_mem_we) o_rdata <= i_mem_dout;
          state <= DONE;
        end
        DONE: begin
          o_gnt <= 2'd3;
          state <= IDLE;
        end
        default: state <= INIT;
      endcase
    end
endmodule

// File: tb/tb_psram_arbiter.sv
// tb_psram_arbiter: randomized self-checking bench for psram_arbiter against a queue-free behavioural arbitration model
module tb_psram_arbiter;
  localparam int LIM = 3;
  logic        clk = 0;
  logic        rst = 0;
  logic [2:0]  req = 0;
  logic [2:0]  we = 0;
  logic [23:0] addr [3];
  logic [15:0] din [3];
  logic        busy = 0;
  logic        done = 0;
  logic [15:0] dout = 0;
  logic [2:0]  ack;
  logic [15:0] rdata;
  logic        ready;
  logic [1:0]  gnt;
  logic        stb;
  logic        mwe;
  logic [23:0] maddr;
  logic [15:0] mdin;
  int checks = 0;
  int errors = 0;
  int m_pref = 1;
  int m_cnt = 0;
  logic [15:0] m_rdata = 0;

  psram_arbiter #(.STARVE_LIMIT(LIM)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_we(we),
    .i_addr0(addr[0]), .i_addr1(addr[1]), .i_addr2(addr[2]),
    .i_din0(din[0]), .i_din1(din[1]), .i_din2(din[2]),
    .o_ack(ack), .o_rdata(rdata), .o_ready(ready), .o_gnt(gnt),
    .o_mem_stb(stb), .o_mem_we(mwe), .o_mem_addr(maddr), .o_mem_din(mdin),
    .i_mem_busy(busy), .i_mem_done(done), .i_mem_dout(dout)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  function automatic int predict(input logic [2:0] r);
    int w;
    bit others = r[1] || r[2];
    if (r[0] && !(others && m_cnt >= LIM)) w = 0;
    else if (r[m_pref]) w = m_pref;
    else w = 3 - m_pref;
    if (w == 0) begin
      if (others && m_cnt < LIM) m_cnt++;
    end else begin
      m_cnt = 0;
      m_pref = 3 - w;
    end
    return w;
  endfunction

  task automatic run_one(input logic [15:0] rd, input bit drop);
    int exp;
    int n;
    logic [23:0] ea;
    logic [15:0] ed;
    logic ew;
    exp = predict(req);
    ea = addr[exp];
    ed = din[exp];
    ew = we[exp];
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!stb && n < 20);
    checks++;
    if (stb !== 1'b1) begin
      $display("FAIL grant_timeout: stb=%b required 1 within 20 cycles (req=%b)", stb, req);
      errors++;
      return;
    end
    checks++;
    if (gnt !== 2'(exp)) begin $display("FAIL grant: gnt=%0d required %0d (req=%b)", gnt, exp, req); errors++; end
    checks++;
    if (maddr !== ea) begin $display("FAIL cmd_addr: got %h required %h", maddr, ea); errors++; end
    checks++;
    if (mwe !== ew) begin $display("FAIL cmd_we: got %b required %b", mwe, ew); errors++; end
    checks++;
    if (mdin !== ed) begin $display("FAIL cmd_din: got %h required %h", mdin, ed); errors++; end
    if (drop) req = 0;
    repeat ($urandom_range(0, 2)) begin
      @(negedge clk);
      checks++;
      if (stb !== 1'b1 || maddr !== ea) begin
        $display("FAIL issue_hold: stb=%b addr=%h required 1/%h", stb, maddr, ea);
        errors++;
      end
    end
    busy = 1;
    @(negedge clk);
    checks++;
    if (stb !== 1'b0) begin $display("FAIL stb_drop: stb=%b required 0", stb); errors++; end
    repeat ($urandom_range(1, 3)) begin
      @(negedge clk);
      checks++;
      if (ack !== 3'b000) begin $display("FAIL early_ack: ack=%b required 000", ack); errors++; end
    end
    busy = 0;
    done = 1;
    dout = rd;
    @(negedge clk);
    done = 0;
    if (!ew) m_rdata = rd;
    checks++;
    if (ack !== (3'b001 << exp)) begin $display("FAIL ack: ack=%b required %b", ack, 3'b001 << exp); errors++; end
    checks++;
    if (rdata !== m_rdata) begin $display("FAIL rdata: got %h required %h", rdata, m_rdata); errors++; end
    checks++;
    if (maddr !== ea || mwe !== ew || mdin !== ed || gnt !== 2'(exp)) begin
      $display("FAIL cmd_held: addr=%h we=%b din=%h gnt=%0d required %h/%b/%h/%0d", maddr, mwe, mdin, gnt, ea, ew, ed, exp);
      errors++;
    end
    @(negedge clk);
    checks++;
    if (ack !== 3'b000 || gnt !== 2'd3) begin
      $display("FAIL release: ack=%b gnt=%0d required 000/3", ack, gnt);
      errors++;
    end
  endtask

  task automatic test_reset;
    #2 rst = 1;
    #1;
    checks++; if (ack !== 3'b000) begin $display("FAIL reset_ack: got %b required 000", ack); errors++; end
    checks++; if (rdata !== 16'h0) begin $display("FAIL reset_rdata: got %h required 0000", rdata); errors++; end
    checks++; if (ready !== 1'b0) begin $display("FAIL reset_ready: got %b required 0", ready); errors++; end
    checks++; if (gnt !== 2'd3) begin $display("FAIL reset_gnt: got %0d required 3", gnt); errors++; end
    checks++; if (stb !== 1'b0) begin $display("FAIL reset_stb: got %b required 0", stb); errors++; end
    checks++; if (mwe !== 1'b0) begin $display("FAIL reset_we: got %b required 0", mwe); errors++; end
    checks++; if (maddr !== 24'h0) begin $display("FAIL reset_addr: got %h required 000000", maddr); errors++; end
    checks++; if (mdin !== 16'h0) begin $display("FAIL reset_din: got %h required 0000", mdin); errors++; end
    repeat (3) @(negedge clk);
    rst = 0;
  endtask

  task automatic test_init;
    req = 3'b111;
    we = 3'b000;
    busy = 1;
    done = 0;
    repeat (1000) begin
      @(negedge clk);
      checks++;
      if (stb !== 1'b0 || ready !== 1'b0) begin
        $display("FAIL init_hold: stb=%b ready=%b required 0/0", stb, ready);
        errors++;
      end
    end
    done = 1;
    @(negedge clk);
    checks++;
    if (ready !== 1'b0 || stb !== 1'b0) begin $display("FAIL init_busy_done: ready=%b stb=%b required 0/0", ready, stb); errors++; end
    busy = 0;
    @(negedge clk);
    done = 0;
    checks++;
    if (ready !== 1'b1) begin $display("FAIL init_exit: ready=%b required 1", ready); errors++; end
    checks++;
    if (stb !== 1'b0) begin $display("FAIL init_no_stb: stb=%b required 0", stb); errors++; end
    run_one(16'($urandom), 1);
  endtask

  task automatic test_read;
    req = 3'b010;
    we = 3'b000;
    addr[1] = 24'h012345;
    run_one(16'hBEEF, 1);
  endtask

  task automatic test_write;
    req = 3'b100;
    we = 3'b100;
    addr[2] = 24'hFFFFFF;
    din[2] = 16'hA55A;
    run_one(16'h1234, 1);
  endtask

  task automatic test_round_robin;
    req = 3'b110;
    we = 3'b000;
    repeat (4) run_one(16'($urandom), 0);
    req = 0;
  endtask

  task automatic test_starve;
    req = 3'b011;
    we = 3'b000;
    repeat (8) run_one(16'($urandom), 0);
    req = 0;
  endtask

  task automatic test_random;
    repeat (40) begin
      req = 3'($urandom_range(1, 7));
      we = 3'($urandom);
      for (int p = 0; p < 3; p++) begin
        addr[p] = 24'($urandom);
        din[p] = 16'($urandom);
      end
      run_one(16'($urandom), 1'($urandom_range(0, 1)));
    end
    req = 0;
  endtask

  task automatic test_mid_reset;
    int n;
    req = 3'b001;
    we = 3'b000;
    addr[0] = 24'h00ABCD;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!stb && n < 20);
    checks++;
    if (stb !== 1'b1) begin $display("FAIL mid_reset_grant: stb=%b required 1", stb); errors++; end
    busy = 1;
    repeat (2) @(negedge clk);
    rst = 1;
    #1;
    checks++;
    if ({ack, rdata, ready, gnt, stb, mwe, maddr, mdin} !== {3'b0, 16'h0, 1'b0, 2'd3, 1'b0, 1'b0, 24'h0, 16'h0}) begin
      $display("FAIL mid_reset_outputs: ack=%b rdata=%h ready=%b gnt=%0d stb=%b we=%b addr=%h din=%h required all reset values",
               ack, rdata, ready, gnt, stb, mwe, maddr, mdin);
      errors++;
    end
    busy = 0;
    done = 1;
    @(negedge clk);
    checks++;
    if (ack !== 3'b000) begin $display("FAIL mid_reset_ack: ack=%b required 000", ack); errors++; end
    busy = 1;
    done = 0;
    rst = 0;
    m_cnt = 0;
    m_pref = 1;
    m_rdata = 0;
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (ready !== 1'b0 || stb !== 1'b0 || gnt !== 2'd3) begin
        $display("FAIL mid_reset_reinit: ready=%b stb=%b gnt=%0d required 0/0/3", ready, stb, gnt);
        errors++;
      end
    end
    busy = 0;
    done = 1;
    @(negedge clk);
    done = 0;
    checks++;
    if (ready !== 1'b1) begin $display("FAIL mid_reset_ready: ready=%b required 1", ready); errors++; end
    run_one(16'h5A5A, 1);
  endtask

  initial begin
    for (int p = 0; p < 3; p++) begin
      addr[p] = 24'h100000 * p + 24'h111;
      din[p] = 16'h1000 * p + 16'h22;
    end
    test_reset;
    test_init;
    test_read;
    test_write;
    test_round_robin;
    test_starve;
    test_random;
    test_mid_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
